// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl
// Sequences a 3x3 Sobel window over a raster-order pixel stream. Tracks the
// row/column of the incoming pixel, drives the register-array shift enable and
// the two line-buffer FIFO enables, and presents each complete window position
// to the gradient stage under a valid/ready handshake. Clears the line buffers
// between frames and recovers from a start-of-frame that arrives mid-frame.
module sobel_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          shift_en,
  output logic          lb0_wr_en,
  output logic          lb0_rd_en,
  output logic          lb1_wr_en,
  output logic          lb1_rd_en,
  output logic          lb_clr,
  output logic          win_valid,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          win_last,
  output logic          frame_done,
  output logic          err_sof
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CLR   = 3'd4
  } state_t;

  localparam logic [CW-1:0] COL_ZERO = CW'(0);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ZERO = RW'(0);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [RW-1:0]   row_r;
  logic [RW-1:0]   row_nxt_s;
  logic [CW-1:0]   col_r;
  logic [CW-1:0]   col_nxt_s;
  logic            done_flag_r;
  logic            done_flag_nxt_s;
  logic            err_sof_r;

  logic            in_frame_s;
  logic            at_origin_s;
  logic            sof_abort_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            take_s;
  logic [RW-1:0]   pix_row_s;
  logic [CW-1:0]   pix_col_s;
  logic            col_last_s;
  logic            row_last_s;
  logic            frame_end_s;
  logic            win_hit_s;

  // Handshake decode: readiness, mid-frame SOF detection and the position of the pixel being taken.
  always_comb begin
    in_frame_s  = (state_r == FILL) || (state_r == RUN);
    at_origin_s = (row_r == ROW_ZERO) && (col_r == COL_ZERO);
    // A new SOF anywhere but the frame origin aborts the frame; the pixel is left pending.
    sof_abort_s = in_valid & in_sof & in_frame_s & ~at_origin_s;
    case (state_r)
      IDLE:      in_ready_s = 1'b1;
      FILL, RUN: in_ready_s = ~sof_abort_s & (~win_valid | out_ready);
      default:   in_ready_s = 1'b0;
    endcase
    accept_s = in_valid & in_ready_s;
    // In IDLE only a SOF pixel enters the datapath; everything else is swallowed.
    take_s   = accept_s & (in_frame_s | in_sof);
    if (in_frame_s) begin
      pix_row_s = row_r;
      pix_col_s = col_r;
    end else begin
      pix_row_s = ROW_ZERO;
      pix_col_s = COL_ZERO;
    end
    col_last_s  = (pix_col_s == COL_LAST);
    row_last_s  = (pix_row_s == ROW_LAST);
    frame_end_s = take_s & col_last_s & row_last_s;
    win_hit_s   = take_s & (pix_row_s >= ROW_TWO) & (pix_col_s >= COL_TWO);
  end

  assign in_ready  = in_ready_s;
  assign shift_en  = take_s;
  assign lb0_wr_en = take_s;
  assign lb0_rd_en = take_s & (pix_row_s != ROW_ZERO);
  assign lb1_wr_en = take_s & (pix_row_s != ROW_ZERO);
  assign lb1_rd_en = take_s & (pix_row_s >= ROW_TWO);
  assign lb_clr    = (state_r == CLR);
  assign err_sof   = err_sof_r | sof_abort_s;

  // Next-state and row/column counter update.
  always_comb begin
    state_nxt_s     = state_r;
    row_nxt_s       = row_r;
    col_nxt_s       = col_r;
    done_flag_nxt_s = done_flag_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          row_nxt_s   = ROW_ZERO;
          col_nxt_s   = COL_ONE;
          state_nxt_s = FILL;
        end else begin
          row_nxt_s = ROW_ZERO;
          col_nxt_s = COL_ZERO;
        end
      end
      FILL, RUN: begin
        if (sof_abort_s) begin
          state_nxt_s     = CLR;
          done_flag_nxt_s = 1'b0;
          row_nxt_s       = ROW_ZERO;
          col_nxt_s       = COL_ZERO;
        end else if (take_s) begin
          if (frame_end_s) begin
            // Park the counters at zero so they never exceed the frame height.
            state_nxt_s = DRAIN;
            row_nxt_s   = ROW_ZERO;
            col_nxt_s   = COL_ZERO;
          end else if (col_last_s) begin
            col_nxt_s = COL_ZERO;
            row_nxt_s = pix_row_s + ROW_ONE;
            if (pix_row_s == ROW_ONE) begin
              state_nxt_s = RUN;
            end else begin
              state_nxt_s = state_r;
            end
          end else begin
            col_nxt_s = pix_col_s + COL_ONE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      DRAIN: begin
        if (win_valid && out_ready) begin
          state_nxt_s     = CLR;
          done_flag_nxt_s = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      CLR: begin
        state_nxt_s     = IDLE;
        done_flag_nxt_s = 1'b0;
        row_nxt_s       = ROW_ZERO;
        col_nxt_s       = COL_ZERO;
      end
      default: begin
        state_nxt_s     = IDLE;
        done_flag_nxt_s = 1'b0;
        row_nxt_s       = ROW_ZERO;
        col_nxt_s       = COL_ZERO;
      end
    endcase
  end

  // State, counters and the frame-complete flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      row_r       <= ROW_ZERO;
      col_r       <= COL_ZERO;
      done_flag_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      row_r       <= row_nxt_s;
      col_r       <= col_nxt_s;
      done_flag_r <= done_flag_nxt_s;
    end
  end

  // Window descriptor: loaded on a qualifying pixel, held until the gradient stage takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_row   <= ROW_ZERO;
      win_col   <= COL_ZERO;
      win_last  <= 1'b0;
    end else if (win_hit_s) begin
      win_valid <= 1'b1;
      win_row   <= pix_row_s - ROW_ONE;
      win_col   <= pix_col_s - COL_ONE;
      win_last  <= row_last_s & col_last_s;
    end else if (sof_abort_s || out_ready) begin
      win_valid <= 1'b0;
    end else begin
      win_valid <= win_valid;
    end
  end

  // Frame-done pulse after the clear cycle of a completed frame, and the sticky SOF error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      err_sof_r  <= 1'b0;
    end else begin
      frame_done <= (state_r == CLR) & done_flag_r;
      err_sof_r  <= err_sof_r | sof_abort_s;
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl
// Directed bench for sobel_window_ctrl at IMG_W=5, IMG_H=4. A frame-index model
// predicts every output on every cycle; literal tables pin window order,
// enable counts and frame_done timing.
module tb_sobel_window_ctrl;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int CW = 3;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_sof, out_ready;
  logic          in_ready, shift_en, lb0_wr_en, lb0_rd_en, lb1_wr_en, lb1_rd_en;
  logic          lb_clr, win_valid, win_last, frame_done, err_sof;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;

  int total = 0;
  int bad   = 0;
  int nprint = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .out_ready(out_ready), .shift_en(shift_en), .lb0_wr_en(lb0_wr_en), .lb0_rd_en(lb0_rd_en),
    .lb1_wr_en(lb1_wr_en), .lb1_rd_en(lb1_rd_en), .lb_clr(lb_clr), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .win_last(win_last), .frame_done(frame_done),
    .err_sof(err_sof)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (nprint < 60) $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      nprint++;
    end
  endtask

  // Model: phase 0 idle, 1 in frame, 2 drain, 3 clear; m_idx = raster index of next pixel.
  int m_phase = 0, m_idx = 0, m_wr = 0, m_wc = 0;
  bit m_wv = 0, m_wl = 0, m_err = 0, m_fd = 0, m_cd = 0, m_init = 0;

  task automatic model_comb(output bit ab, output bit rdy, output bit tk, output int r, output int c);
    int pidx;
    ab = (in_valid === 1'b1) && (in_sof === 1'b1) && m_phase == 1 && m_idx != 0;
    if (m_phase == 0) rdy = 1'b1;
    else if (m_phase == 1) rdy = !ab && (!m_wv || out_ready === 1'b1);
    else rdy = 1'b0;
    tk = (in_valid === 1'b1) && rdy && (m_phase == 1 || in_sof === 1'b1);
    pidx = (m_phase == 1) ? m_idx : 0;
    r = pidx / W;
    c = pidx % W;
  endtask

  // Model update at the active edge.
  always @(posedge clk) begin
    bit ab, rdy, tk, hs;
    int r, c;
    model_comb(ab, rdy, tk, r, c);
    cyc++;
    if (rst_n !== 1'b1) begin
      m_init = 1; m_phase = 0; m_idx = 0; m_wv = 0; m_wl = 0; m_wr = 0; m_wc = 0;
      m_err = 0; m_fd = 0; m_cd = 0;
    end else begin
      hs   = m_wv && out_ready === 1'b1;
      m_fd = (m_phase == 3) && m_cd;
      case (m_phase)
        0: if (tk) begin m_phase = 1; m_idx = 1; end
        1: begin
          if (ab) begin m_phase = 3; m_cd = 0; m_err = 1; m_idx = 0; end
          else if (tk) begin
            if (r * W + c == W * H - 1) begin m_phase = 2; m_idx = 0; end
            else m_idx = m_idx + 1;
          end
        end
        2: if (hs) begin m_phase = 3; m_cd = 1; end
        default: begin m_phase = 0; m_cd = 0; end
      endcase
      if (tk && r >= 2 && c >= 2) begin
        m_wv = 1; m_wr = r - 1; m_wc = c - 1; m_wl = (r == H - 1) && (c == W - 1);
      end else if (ab || out_ready === 1'b1) begin
        m_wv = 0;
      end
    end
  end

  // Compare every output with the model on the inactive edge.
  always @(negedge clk) begin
    bit ab, rdy, tk;
    int r, c;
    if (m_init) begin
      model_comb(ab, rdy, tk, r, c);
      check("in_ready", 32'(in_ready), 32'(rdy));
      check("shift_en", 32'(shift_en), 32'(tk));
      check("lb0_wr_en", 32'(lb0_wr_en), 32'(tk));
      check("lb0_rd_en", 32'(lb0_rd_en), 32'(tk && r >= 1));
      check("lb1_wr_en", 32'(lb1_wr_en), 32'(tk && r >= 1));
      check("lb1_rd_en", 32'(lb1_rd_en), 32'(tk && r >= 2));
      check("lb_clr", 32'(lb_clr), 32'(m_phase == 3));
      check("win_valid", 32'(win_valid), 32'(m_wv));
      if (m_wv) begin
        check("win_row", 32'(win_row), 32'(m_wr));
        check("win_col", 32'(win_col), 32'(m_wc));
        check("win_last", 32'(win_last), 32'(m_wl));
      end
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("err_sof", 32'(err_sof), 32'(m_err || ab));
    end
  end

  // Event log used by the literal frame checks.
  int n_shift, n_l0w, n_l0r, n_l1w, n_l1r, n_clr, n_fd, n_win, hs_cyc, fd_cyc;
  int log_r[16], log_c[16], log_l[16];

  task automatic clear_log();
    n_shift = 0; n_l0w = 0; n_l0r = 0; n_l1w = 0; n_l1r = 0;
    n_clr = 0; n_fd = 0; n_win = 0; hs_cyc = -100; fd_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      n_shift += int'(shift_en === 1'b1);
      n_l0w   += int'(lb0_wr_en === 1'b1);
      n_l0r   += int'(lb0_rd_en === 1'b1);
      n_l1w   += int'(lb1_wr_en === 1'b1);
      n_l1r   += int'(lb1_rd_en === 1'b1);
      n_clr   += int'(lb_clr === 1'b1);
      if (frame_done === 1'b1) begin n_fd++; fd_cyc = cyc; end
      if (win_valid === 1'b1 && out_ready === 1'b1 && n_win < 16) begin
        log_r[n_win] = int'(win_row);
        log_c[n_win] = int'(win_col);
        log_l[n_win] = int'(win_last);
        if (win_last === 1'b1) hs_cyc = cyc;
        n_win++;
      end
    end
  end

  task automatic check_frame(input string tag);
    int er[6] = '{1, 1, 1, 2, 2, 2};
    int ec[6] = '{1, 2, 3, 1, 2, 3};
    int el[6] = '{0, 0, 0, 0, 0, 1};
    check({tag, "_win_count"}, n_win, 6);
    for (int k = 0; k < 6; k++) begin
      if (k < n_win) begin
        check({tag, "_win_row"}, log_r[k], er[k]);
        check({tag, "_win_col"}, log_c[k], ec[k]);
        check({tag, "_win_last"}, log_l[k], el[k]);
      end
    end
    check({tag, "_shift_cnt"}, n_shift, 20);
    check({tag, "_lb0_wr_cnt"}, n_l0w, 20);
    check({tag, "_lb0_rd_cnt"}, n_l0r, 15);
    check({tag, "_lb1_wr_cnt"}, n_l1w, 15);
    check({tag, "_lb1_rd_cnt"}, n_l1r, 10);
    check({tag, "_lb_clr_cnt"}, n_clr, 1);
    check({tag, "_frame_done_cnt"}, n_fd, 1);
    check({tag, "_frame_done_delay"}, fd_cyc - hs_cyc, 2);
  endtask

  task automatic send_pixel(input bit sof);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("pixel_accept_timeout", 32'd0, 32'd1);
    in_sof = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout reached time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    clear_log();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_win_valid", 32'(win_valid), 32'd0);
    check("rst_err_sof", 32'(err_sof), 32'd0);
    check("rst_lb_clr", 32'(lb_clr), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame 1: back-to-back pixels, gradient stage always ready.
    clear_log();
    for (int i = 0; i < 20; i++) send_pixel(i == 0);
    idle_cycles(6);
    check_frame("f1");

    // Frame 2: stall window (1,2) for three cycles.
    clear_log();
    for (int i = 0; i < 14; i++) send_pixel(i == 0);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 14; i < 20; i++) send_pixel(1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_win_valid", 32'(win_valid), 32'd1);
          check("stall_win_row", 32'(win_row), 32'd1);
          check("stall_win_col", 32'(win_col), 32'd2);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle_cycles(6);
    check_frame("stall");

    // Pixels without SOF in IDLE are swallowed.
    in_valid = 1'b1; in_sof = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_shift_en", 32'(shift_en), 32'd0);
      @(posedge clk); #1;
    end
    idle_cycles(2);

    // SOF arriving at pixel index 7 aborts the frame.
    for (int i = 0; i < 7; i++) send_pixel(i == 0);
    in_valid = 1'b1; in_sof = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_err_sof", 32'(err_sof), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_lb_clr", 32'(lb_clr), 32'd1);
    check("abort_err_sticky", 32'(err_sof), 32'd1);
    check("abort_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    clear_log();
    send_pixel(1'b1);
    for (int i = 1; i < 20; i++) send_pixel(1'b0);
    idle_cycles(6);
    check_frame("resof");
    check("resof_err_sticky", 32'(err_sof), 32'd1);

    // Reset for one clock in the middle of RUN.
    for (int i = 0; i < 13; i++) send_pixel(i == 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_win_valid", 32'(win_valid), 32'd0);
    check("midrst_err_sof", 32'(err_sof), 32'd0);
    check("midrst_lb_clr", 32'(lb_clr), 32'd0);
    @(posedge clk); #1;
    clear_log();
    for (int i = 0; i < 20; i++) send_pixel(i == 0);
    idle_cycles(6);
    check_frame("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
